// File: rtl/isr_priority_sequencer.sv
// Priority resolver and INTA sequencer for an 8-level interrupt controller:
// rotating fully nested priority, two-pulse acknowledge, AEOI and EOI handling.
module isr_priority_sequencer #(
    parameter int VEC_BASE_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            irr,
    input  logic                  inta_n,
    input  logic                  aeoi,
    input  logic                  rotate_on_aeoi,
    input  logic                  eoi_valid,
    input  logic                  eoi_specific,
    input  logic                  eoi_rotate,
    input  logic [2:0]            eoi_level,
    input  logic [VEC_BASE_W-1:0] vector_base,
    output logic                  int_out,
    output logic [7:0]            vector_out,
    output logic                  vector_valid,
    output logic [7:0]            isr,
    output logic [7:0]            clear_irr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACK1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] lowest_prio_q, lowest_prio_d;
    logic       inta_n_q, inta_n_d;
    logic       int_out_q, int_out_d;
    logic [2:0] winner_q, winner_d;
    logic       spurious_q, spurious_d;
    logic [7:0] vector_out_q, vector_out_d;
    logic       vector_valid_q, vector_valid_d;
    logic [7:0] clear_irr_q, clear_irr_d;

    // Rotate so that bit 0 is the highest-priority level (lowest_prio + 1).
    function automatic logic [7:0] rotr(input logic [7:0] v, input logic [2:0] sh);
        return 8'(({v, v}) >> sh);
    endfunction

    // Index of the lowest set bit, 8 when the vector is empty.
    function automatic logic [3:0] first_set(input logic [7:0] v);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    logic [2:0] base;
    logic [3:0] irr_rank;
    logic [3:0] isr_rank;
    logic       elig_found;
    logic [2:0] elig_level;
    logic [2:0] isr_top_level;
    logic       inta_fall;

    // NOTE: always_comb uses blocking '=' and assigns every output first so no latch is inferred.
    always_comb begin
        base          = lowest_prio_q + 3'd1;
        irr_rank      = first_set(rotr(irr, base));
        isr_rank      = first_set(rotr(isr_q, base));
        elig_found    = (irr_rank < isr_rank);
        elig_level    = base + irr_rank[2:0];
        isr_top_level = base + isr_rank[2:0];
        inta_fall     = inta_n_q & ~inta_n;
    end

    logic       eoi_exec;
    logic [2:0] eoi_sel;
    logic [7:0] eoi_clr_mask;

    always_comb begin
        eoi_sel      = eoi_specific ? eoi_level : isr_top_level;
        eoi_exec     = eoi_valid & (eoi_specific ? isr_q[eoi_level] : (isr_q != 8'd0));
        eoi_clr_mask = eoi_exec ? (8'd1 << eoi_sel) : 8'd0;
    end

    logic [7:0] isr_set_mask;
    logic [7:0] aeoi_clr_mask;
    logic       aeoi_rot;

    always_comb begin
        state_d        = state_q;
        int_out_d      = int_out_q;
        winner_d       = winner_q;
        spurious_d     = spurious_q;
        vector_out_d   = vector_out_q;
        vector_valid_d = 1'b0;
        clear_irr_d    = 8'd0;
        isr_set_mask   = 8'd0;
        aeoi_clr_mask  = 8'd0;
        aeoi_rot       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                int_out_d = elig_found;
                if (elig_found) state_d = ST_PEND;
            end
            ST_PEND: begin
                // int_out is held even if the request is withdrawn before acknowledge.
                if (inta_fall) begin
                    int_out_d = 1'b0;
                    state_d   = ST_ACK1;
                    if (elig_found) begin
                        winner_d     = elig_level;
                        spurious_d   = 1'b0;
                        isr_set_mask = 8'd1 << elig_level;
                        clear_irr_d  = 8'd1 << elig_level;
                    end else begin
                        winner_d   = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                int_out_d = 1'b0;
                if (inta_fall) begin
                    vector_valid_d = 1'b1;
                    vector_out_d   = 8'({vector_base, winner_q});
                    state_d        = ST_IDLE;
                    if (aeoi && !spurious_q) begin
                        aeoi_clr_mask = 8'd1 << winner_q;
                        aeoi_rot      = rotate_on_aeoi;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                int_out_d = 1'b0;
            end
        endcase
    end

    // Clears are applied before the acknowledge set, so a set on the same bit wins.
    always_comb begin
        isr_d = (isr_q & ~eoi_clr_mask & ~aeoi_clr_mask) | isr_set_mask;
        if (eoi_exec && eoi_rotate) begin
            lowest_prio_d = eoi_sel;
        end else if (aeoi_rot) begin
            lowest_prio_d = winner_q;
        end else begin
            lowest_prio_d = lowest_prio_q;
        end
        inta_n_d = inta_n;
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            isr_q          <= 8'd0;
            lowest_prio_q  <= 3'd7;
            inta_n_q       <= 1'b1;
            int_out_q      <= 1'b0;
            winner_q       <= 3'd0;
            spurious_q     <= 1'b0;
            vector_out_q   <= 8'd0;
            vector_valid_q <= 1'b0;
            clear_irr_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            isr_q          <= isr_d;
            lowest_prio_q  <= lowest_prio_d;
            inta_n_q       <= inta_n_d;
            int_out_q      <= int_out_d;
            winner_q       <= winner_d;
            spurious_q     <= spurious_d;
            vector_out_q   <= vector_out_d;
            vector_valid_q <= vector_valid_d;
            clear_irr_q    <= clear_irr_d;
        end
    end

    assign int_out      = int_out_q;
    assign vector_out   = vector_out_q;
    assign vector_valid = vector_valid_q;
    assign isr          = isr_q;
    assign clear_irr    = clear_irr_q;

endmodule

// File: tb/tb_isr_priority_sequencer.sv
// Directed vector table for the acknowledge/EOI corner cases, then randomized
// traffic compared cycle by cycle against a priority-rule reference model.
module tb_isr_priority_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irr;
    logic       inta_n;
    logic       aeoi;
    logic       rotate_on_aeoi;
    logic       eoi_valid;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic [7:0] isr;
    logic [7:0] clear_irr;

    int checks   = 0;
    int failures = 0;

    isr_priority_sequencer #(.VEC_BASE_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irr            (irr),
        .inta_n         (inta_n),
        .aeoi           (aeoi),
        .rotate_on_aeoi (rotate_on_aeoi),
        .eoi_valid      (eoi_valid),
        .eoi_specific   (eoi_specific),
        .eoi_rotate     (eoi_rotate),
        .eoi_level      (eoi_level),
        .vector_base    (vector_base),
        .int_out        (int_out),
        .vector_out     (vector_out),
        .vector_valid   (vector_valid),
        .isr            (isr),
        .clear_irr      (clear_irr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [7:0] irr;
        logic       inta_n;
        logic       aeoi;
        logic       rot;
        logic       ev;
        logic       es;
        logic       er;
        logic [2:0] el;
        logic       e_int;
        logic       e_vv;
        logic [7:0] e_vo;
        logic [7:0] e_isr;
        logic [7:0] e_clr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] i, input logic ia, input logic a, input logic ro,
                       input logic ev, input logic es, input logic er, input logic [2:0] el,
                       input logic ei, input logic evv, input logic [7:0] evo,
                       input logic [7:0] eisr, input logic [7:0] eclr);
        vec_t v;
        v.rst_n = r;  v.irr = i;   v.inta_n = ia; v.aeoi = a;  v.rot = ro;
        v.ev = ev;    v.es = es;   v.er = er;     v.el = el;
        v.e_int = ei; v.e_vv = evv; v.e_vo = evo; v.e_isr = eisr; v.e_clr = eclr;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    int         m_phase;  // 0 waiting for request, 1 awaiting first INTA, 2 awaiting second
    logic [7:0] m_isr;
    int         m_lp;
    logic       m_prev;
    int         m_winner;
    logic       m_spur;
    logic       m_int, m_vv;
    logic [7:0] m_vo, m_clr;

    // Position in the priority order, 0 = highest.
    function automatic int prio_pos(input int lvl, input int lp);
        return (lvl - lp + 7) % 8;
    endfunction

    function automatic int top_level(input logic [7:0] v, input int lp);
        for (int p = 1; p <= 8; p++) begin
            if (v[(lp + p) % 8]) return (lp + p) % 8;
        end
        return -1;
    endfunction

    function automatic int eligible(input logic [7:0] req, input logic [7:0] svc, input int lp);
        int t, s;
        t = top_level(req, lp);
        s = top_level(svc, lp);
        if (t >= 0 && (s < 0 || prio_pos(t, lp) < prio_pos(s, lp))) return t;
        return -1;
    endfunction

    task automatic model_step();
        logic       fall;
        int         elig;
        int         eoi_lvl;
        logic [7:0] nisr;
        int         nlp;
        logic       aeoi_rot;
        logic [2:0] w;
        if (!rst_n) begin
            m_phase = 0; m_isr = 8'h00; m_lp = 7; m_prev = 1'b1; m_winner = 0; m_spur = 1'b0;
            m_int = 1'b0; m_vv = 1'b0; m_vo = 8'h00; m_clr = 8'h00;
            return;
        end
        fall    = m_prev && !inta_n;
        elig    = eligible(irr, m_isr, m_lp);
        eoi_lvl = -1;
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (m_isr[eoi_level]) eoi_lvl = int'(eoi_level);
            end else begin
                eoi_lvl = top_level(m_isr, m_lp);
            end
        end
        nisr     = m_isr;
        nlp      = m_lp;
        aeoi_rot = 1'b0;
        if (eoi_lvl >= 0) nisr[eoi_lvl] = 1'b0;
        m_vv  = 1'b0;
        m_clr = 8'h00;
        case (m_phase)
            0: begin
                m_int = (elig >= 0);
                if (elig >= 0) m_phase = 1;
            end
            1: if (fall) begin
                m_int   = 1'b0;
                m_phase = 2;
                if (elig >= 0) begin
                    m_winner     = elig;
                    m_spur       = 1'b0;
                    nisr[elig]   = 1'b1;
                    m_clr[elig]  = 1'b1;
                end else begin
                    m_winner = 7;
                    m_spur   = 1'b1;
                end
            end
            default: if (fall) begin
                w       = m_winner[2:0];
                m_vv    = 1'b1;
                m_vo    = {vector_base, w};
                m_phase = 0;
                if (aeoi && !m_spur) begin
                    nisr[m_winner] = 1'b0;
                    aeoi_rot       = rotate_on_aeoi;
                end
            end
        endcase
        if (eoi_lvl >= 0 && eoi_rotate) nlp = eoi_lvl;
        else if (aeoi_rot)              nlp = m_winner;
        m_isr  = nisr;
        m_lp   = nlp;
        m_prev = inta_n;
    endtask

    initial begin
        logic [7:0] irr_r;
        rst_n = 1'b0; irr = 8'h00; inta_n = 1'b1; aeoi = 1'b0; rotate_on_aeoi = 1'b0;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;
        vector_base = 5'h08;

        //   rst irr  inta aeo rot ev es er el   int vv vo     isr    clr
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h28, 1, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h28, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h08);
        add(1, 8'h20, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00);
        add(1, 8'h20, 0, 0, 0, 0, 0, 0, 0,  0, 1, 8'h43, 8'h08, 8'h00);
        add(1, 8'h20, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h08, 8'h00);
        add(1, 8'h22, 1, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h08, 8'h00);
        add(1, 8'h22, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h0A, 8'h02);
        add(1, 8'h20, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h0A, 8'h00);
        add(1, 8'h20, 0, 0, 0, 0, 0, 0, 0,  0, 1, 8'h41, 8'h0A, 8'h00);
        add(1, 8'h20, 1, 0, 0, 1, 0, 1, 0,  0, 0, 8'h00, 8'h08, 8'h00);
        add(1, 8'h05, 1, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h08, 8'h00);
        add(1, 8'h05, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h0C, 8'h04);
        add(1, 8'h01, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h0C, 8'h00);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 0,  0, 1, 8'h42, 8'h0C, 8'h00);
        add(1, 8'h00, 1, 0, 0, 1, 1, 0, 2,  0, 0, 8'h00, 8'h08, 8'h00);
        add(1, 8'h00, 1, 0, 0, 1, 1, 0, 3,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h00, 1, 0, 0, 1, 1, 1, 3,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h04, 1, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h00, 1, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h00, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0,  0, 1, 8'h47, 8'h00, 8'h00);
        add(1, 8'h01, 1, 1, 1, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h01, 0, 1, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h01, 8'h01);
        add(1, 8'h00, 1, 1, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h01, 8'h00);
        add(1, 8'h00, 0, 1, 1, 0, 0, 0, 0,  0, 1, 8'h40, 8'h00, 8'h00);
        add(1, 8'h03, 1, 1, 1, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h03, 0, 1, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h02, 8'h02);
        add(1, 8'h01, 1, 1, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h02, 8'h00);
        add(1, 8'h01, 0, 1, 1, 0, 0, 0, 0,  0, 1, 8'h41, 8'h00, 8'h00);
        add(1, 8'h01, 1, 1, 1, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h01, 0, 1, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h01, 8'h01);
        add(0, 8'h00, 1, 1, 1, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h81, 1, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h81, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h01, 8'h01);
        add(1, 8'h80, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h01, 8'h00);
        add(1, 8'h80, 0, 0, 0, 0, 0, 0, 0,  0, 1, 8'h40, 8'h01, 8'h00);
        add(1, 8'h80, 1, 0, 0, 1, 0, 0, 0,  0, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h80, 1, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 8'h00, 8'h00);
        add(1, 8'h80, 0, 0, 0, 1, 1, 1, 7,  0, 0, 8'h00, 8'h80, 8'h80);
        add(1, 8'h00, 1, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 8'h80, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0,  0, 1, 8'h47, 8'h80, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;     irr = vecs[i].irr;          inta_n = vecs[i].inta_n;
            aeoi = vecs[i].aeoi;       rotate_on_aeoi = vecs[i].rot;
            eoi_valid = vecs[i].ev;    eoi_specific = vecs[i].es;
            eoi_rotate = vecs[i].er;   eoi_level = vecs[i].el;
            @(posedge clk);
            #1;
            check($sformatf("row%0d int_out", i),      32'(int_out),      32'(vecs[i].e_int));
            check($sformatf("row%0d vector_valid", i), 32'(vector_valid), 32'(vecs[i].e_vv));
            check($sformatf("row%0d isr", i),          32'(isr),          32'(vecs[i].e_isr));
            check($sformatf("row%0d clear_irr", i),    32'(clear_irr),    32'(vecs[i].e_clr));
            if (vecs[i].e_vv || !vecs[i].rst_n)
                check($sformatf("row%0d vector_out", i), 32'(vector_out), 32'(vecs[i].e_vo));
        end

        // Randomized traffic against the reference model, starting from reset.
        irr_r = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) irr_r = 8'($urandom) & 8'($urandom);
            irr_r          = irr_r & ~clear_irr;
            irr            = irr_r;
            inta_n         = 1'($urandom);
            aeoi           = 1'($urandom);
            rotate_on_aeoi = 1'($urandom);
            eoi_valid      = ($urandom_range(0, 5) == 0);
            eoi_specific   = 1'($urandom);
            eoi_rotate     = 1'($urandom);
            eoi_level      = 3'($urandom);
            if (cyc % 64 == 0) vector_base = 5'($urandom);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d int_out", cyc),      32'(int_out),      32'(m_int));
            check($sformatf("rnd%0d vector_valid", cyc), 32'(vector_valid), 32'(m_vv));
            check($sformatf("rnd%0d isr", cyc),          32'(isr),          32'(m_isr));
            check($sformatf("rnd%0d clear_irr", cyc),    32'(clear_irr),    32'(m_clr));
            if (m_vv || !rst_n)
                check($sformatf("rnd%0d vector_out", cyc), 32'(vector_out), 32'(m_vo));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
